// File: rtl/aux_button_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// aux_button_debouncer_pkg
//   Shared definitions for the push-button conditioner:
//   - deb_state_t : per-channel debounce FSM state encoding (2 bits)
//   - cnt_hz / cnt_khz / cnt_mhz / cnt_ms : cycle-count helpers used when
//     sizing StableCnt / LongCnt from a clock frequency and a wall-clock time.
// -----------------------------------------------------------------------------
package aux_button_debouncer_pkg;

    // Per-channel debounce FSM states.
    typedef enum logic [1:0] {
        DEB_ST_IDLE    = 2'd0,  // level low, input quiet
        DEB_ST_PRESS   = 2'd1,  // input went active, qualifying the press
        DEB_ST_HELD    = 2'd2,  // level high, hold timer running
        DEB_ST_RELEASE = 2'd3   // input went inactive, qualifying the release
    } deb_state_t;

    // Number of flops in the input synchroniser.
    localparam int unsigned DEB_SYNC_STAGES = 2;

    // Cycles in one period of a tick of the given rate.
    function automatic longint unsigned cnt_hz(input longint unsigned clk_hz,
                                               input longint unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic longint unsigned cnt_khz(input longint unsigned clk_hz,
                                                input longint unsigned tick_khz);
        return clk_hz / (tick_khz * 64'd1000);
    endfunction

    function automatic longint unsigned cnt_mhz(input longint unsigned clk_hz,
                                                input longint unsigned tick_mhz);
        return clk_hz / (tick_mhz * 64'd1000000);
    endfunction

    // Cycles spanning the given number of milliseconds.
    function automatic longint unsigned cnt_ms(input longint unsigned clk_hz,
                                               input longint unsigned ms);
        return (clk_hz / 64'd1000) * ms;
    endfunction

endpackage

// File: rtl/aux_button_debouncer_channel.sv
// -----------------------------------------------------------------------------
// aux_button_debouncer_channel
//   One button channel: 2-FF synchroniser, debounce FSM, shared-width debounce
//   and hold counters, registered level and event pulses.
//
// Ports
//   clk        in   1  clock
//   rst_n      in   1  asynchronous active-low reset
//   i_btn      in   1  raw button, already polarity-normalised (1 = pressed)
//   o_level    out  1  debounced level
//   o_press    out  1  1-cycle pulse as o_level rises
//   o_release  out  1  1-cycle pulse as o_level falls
//   o_long     out  1  1-cycle pulse LongCnt cycles after o_press, once per press
// -----------------------------------------------------------------------------
module aux_button_debouncer_channel
    import aux_button_debouncer_pkg::*;
#(
    parameter int unsigned StableCnt = 2_000_000,
    parameter int unsigned LongCnt   = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    // One width for both counters, wide enough to hold LongCnt without wrap.
    localparam int unsigned CntW = $clog2(LongCnt + 1);

    localparam logic [CntW-1:0] STABLE_LAST = CntW'(StableCnt - 1);
    localparam logic [CntW-1:0] LONG_LAST   = CntW'(LongCnt - 1);
    localparam logic [CntW-1:0] LONG_MAX    = CntW'(LongCnt);
    localparam logic [CntW-1:0] CNT_ONE     = CntW'(1);

    logic [DEB_SYNC_STAGES-1:0] r_sync;
    deb_state_t                 r_state;
    logic [CntW-1:0]            r_dcnt;
    logic [CntW-1:0]            r_hcnt;
    logic                       r_level;
    logic                       r_press;
    logic                       r_release;
    logic                       r_long;

    logic                       w_s;
    logic [CntW-1:0]            w_hcnt_inc;
    logic                       w_long_hit;

    assign w_s = r_sync[DEB_SYNC_STAGES-1];

    // Hold timer parks at LongCnt, so the long pulse cannot fire twice
    // for the same press no matter how long the button is held.
    assign w_hcnt_inc = (r_hcnt == LONG_MAX) ? r_hcnt : (r_hcnt + CNT_ONE);
    assign w_long_hit = (r_hcnt == LONG_LAST);

    // Synchroniser runs every cycle, independent of FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEB_SYNC_STAGES-2:0], i_btn};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= DEB_ST_IDLE;
            r_dcnt    <= '0;
            r_hcnt    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            // Pulses are single-cycle unless re-asserted below.
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;

            case (r_state)
                DEB_ST_IDLE: begin
                    r_hcnt <= '0;
                    if (w_s) begin
                        // This cycle already counts as the first stable one.
                        r_state <= DEB_ST_PRESS;
                        r_dcnt  <= CNT_ONE;
                    end else begin
                        r_dcnt  <= '0;
                    end
                end

                DEB_ST_PRESS: begin
                    if (!w_s) begin
                        // Bounce: abandon and start over from zero.
                        r_state <= DEB_ST_IDLE;
                        r_dcnt  <= '0;
                    end else if (r_dcnt == STABLE_LAST) begin
                        r_state <= DEB_ST_HELD;
                        r_dcnt  <= '0;
                        r_hcnt  <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_dcnt  <= r_dcnt + CNT_ONE;
                    end
                end

                DEB_ST_HELD: begin
                    r_hcnt <= w_hcnt_inc;
                    r_long <= w_long_hit;
                    if (!w_s) begin
                        r_state <= DEB_ST_RELEASE;
                        r_dcnt  <= CNT_ONE;
                    end
                end

                DEB_ST_RELEASE: begin
                    // Level is still high here, so the hold timer keeps running
                    // and a long pulse may still land during release qualification.
                    r_hcnt <= w_hcnt_inc;
                    r_long <= w_long_hit;
                    if (w_s) begin
                        r_state <= DEB_ST_HELD;
                        r_dcnt  <= '0;
                    end else if (r_dcnt == STABLE_LAST) begin
                        r_state   <= DEB_ST_IDLE;
                        r_dcnt    <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_dcnt    <= r_dcnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state <= DEB_ST_IDLE;
                    r_dcnt  <= '0;
                    r_hcnt  <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule

// File: rtl/aux_button_debouncer.sv
// -----------------------------------------------------------------------------
// aux_button_debouncer
//   Multi-channel push-button conditioner. Raw board buttons are normalised to
//   active-high, then each channel is synchronised and debounced independently.
//
// Parameters
//   Channels   number of independent buttons (1..16)
//   ActiveLow  1: raw pin reads 0 when pressed
//   StableCnt  cycles the synchronised input must stay changed before the level flips (>=2)
//   LongCnt    cycles of asserted level before the long pulse (>StableCnt)
//
// Ports
//   clk          in   1         board clock
//   rst_n        in   1         asynchronous active-low reset
//   btn_raw      in   Channels  raw button pins, asynchronous to clk
//   btn_level    out  Channels  debounced level, 1 = pressed
//   btn_press    out  Channels  1-cycle pulse as btn_level rises
//   btn_release  out  Channels  1-cycle pulse as btn_level falls
//   btn_long     out  Channels  1-cycle pulse LongCnt cycles after btn_press
// -----------------------------------------------------------------------------
module aux_button_debouncer
    import aux_button_debouncer_pkg::*;
#(
    parameter int unsigned Channels  = 1,
    parameter bit          ActiveLow = 1'b0,
    parameter int unsigned StableCnt = 2_000_000,
    parameter int unsigned LongCnt   = 100_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [Channels-1:0] btn_raw,
    output logic [Channels-1:0] btn_level,
    output logic [Channels-1:0] btn_press,
    output logic [Channels-1:0] btn_release,
    output logic [Channels-1:0] btn_long
);

    // Polarity is fixed before the synchroniser so reset-state sync flops
    // always mean "not pressed".
    logic [Channels-1:0] w_pin;

    assign w_pin = btn_raw ^ {Channels{ActiveLow}};

    for (genvar g = 0; g < Channels; g++) begin : g_ch
        aux_button_debouncer_channel #(
            .StableCnt (StableCnt),
            .LongCnt   (LongCnt)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_btn     (w_pin[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g]),
            .o_long    (btn_long[g])
        );
    end

endmodule

// File: tb/tb_aux_button_debouncer.sv
module tb_aux_button_debouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_long;

    int n_cmp = 0;
    int n_err = 0;
    int np[2];
    int nr[2];
    int nl[2];

    always #5 clk = ~clk;

    aux_button_debouncer #(
        .Channels  (2),
        .ActiveLow (1'b1),
        .StableCnt (4),
        .LongCnt   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            np[i] = 0;
            nr[i] = 0;
            nl[i] = 0;
        end
    endtask

    // Advance one clock and sample 1 ns after the edge, tallying pulses.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (btn_press[i])   np[i]++;
            if (btn_release[i]) nr[i]++;
            if (btn_long[i])    nl[i]++;
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    initial begin
        clr();
        // Reset with both raw pins high (released, active-low)
        rst_n   = 1'b0;
        btn_raw = 2'b11;
        steps(3);
        chk("rst_level",   32'(btn_level),   0);
        chk("rst_press",   32'(btn_press),   0);
        chk("rst_release", 32'(btn_release), 0);
        chk("rst_long",    32'(btn_long),    0);
        rst_n = 1'b1;
        clr();
        steps(20);
        chk("idle_level",  32'(btn_level), 0);
        chk("idle_pulses", np[0] + np[1] + nr[0] + nr[1] + nl[0] + nl[1], 0);

        // Clean press on ch0: level at T+6, release pulse at T+36
        clr();
        btn_raw = 2'b10;
        steps(5);
        chk("cp_pre_level", 32'(btn_level), 0);
        chk("cp_pre_press", np[0], 0);
        step();
        chk("cp_level", 32'(btn_level), 2'b01);
        chk("cp_press", 32'(btn_press), 2'b01);
        step();
        chk("cp_press_1cyc", 32'(btn_press), 0);
        chk("cp_level_hold", 32'(btn_level), 2'b01);
        steps(23);
        btn_raw = 2'b11;
        steps(5);
        chk("cr_pre_level",   32'(btn_level), 2'b01);
        chk("cr_pre_release", nr[0], 0);
        step();
        chk("cr_level",    32'(btn_level),   0);
        chk("cr_release",  32'(btn_release), 2'b01);
        chk("cr_no_press", 32'(btn_press),   0);
        step();
        chk("cr_release_1cyc", 32'(btn_release), 0);
        chk("cp_press_cnt", np[0], 1);
        chk("cp_long_once", nl[0], 1);

        // Bounce on ch0: 3 low, 1 high, 3 low -> nothing
        clr();
        btn_raw = 2'b10; steps(3);
        btn_raw = 2'b11; steps(1);
        btn_raw = 2'b10; steps(3);
        btn_raw = 2'b11; steps(15);
        chk("bn_level",   32'(btn_level), 0);
        chk("bn_press",   np[0], 0);
        chk("bn_release", nr[0], 0);

        // Exactly StableCnt low cycles is enough to register a press
        clr();
        btn_raw = 2'b10; steps(4);
        btn_raw = 2'b11; steps(2);
        chk("edge_press", 32'(btn_press), 2'b01);
        steps(4);
        chk("edge_release", 32'(btn_release), 2'b01);
        steps(5);
        chk("edge_counts", np[0] * 10 + nr[0], 11);

        // Long press on ch1, held 40 cycles
        clr();
        btn_raw = 2'b01;
        steps(6);
        chk("lp_press", 32'(btn_press), 2'b10);
        steps(15);
        chk("lp_pre_long", nl[1], 0);
        step();
        chk("lp_long", 32'(btn_long), 2'b10);
        step();
        chk("lp_long_1cyc", 32'(btn_long), 0);
        steps(17);
        btn_raw = 2'b11;
        steps(10);
        chk("lp_long_once", nl[1], 1);
        chk("lp_release",   nr[1], 1);
        chk("lp_level",     32'(btn_level), 0);

        // Short press on ch1, raw held 10 cycles -> no long
        clr();
        btn_raw = 2'b01; steps(10);
        btn_raw = 2'b11; steps(20);
        chk("sp_press",   np[1], 1);
        chk("sp_release", nr[1], 1);
        chk("sp_no_long", nl[1], 0);

        // Simultaneous press; ch0 bounce must not disturb either channel
        clr();
        btn_raw = 2'b00;
        steps(6);
        chk("sim_press", 32'(btn_press), 2'b11);
        chk("sim_level", 32'(btn_level), 2'b11);
        btn_raw = 2'b01; steps(3);
        btn_raw = 2'b00; steps(1);
        btn_raw = 2'b01; steps(2);
        btn_raw = 2'b00; steps(10);
        chk("sim_level_kept", 32'(btn_level), 2'b11);
        chk("sim_no_release", nr[0] + nr[1], 0);
        btn_raw = 2'b11;
        steps(6);
        chk("sim_release", 32'(btn_release), 2'b11);
        steps(5);

        // Reset while ch0 is qualifying a press
        clr();
        btn_raw = 2'b10;
        steps(3);
        rst_n = 1'b0;
        steps(2);
        chk("rm_level_in_rst", 32'(btn_level), 0);
        rst_n = 1'b1;
        steps(5);
        chk("rm_no_press", np[0], 0);
        step();
        chk("rm_press", 32'(btn_press), 2'b01);

        // Reset acts asynchronously on a held level
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_level", 32'(btn_level), 0);
        btn_raw = 2'b11;
        #5;
        rst_n = 1'b1;
        steps(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
